// File: rtl/irq_nest_ctrl.sv
// irq_nest_ctrl: core-side interrupt acceptor with preemption check, trap handshake and nested-level stack
// Ports: clk_i/rst_i (async active-high reset); irq_valid_i/irq_id_i/irq_level_i/irq_heti_i/irq_nest_i arbitrated
// request from the controller; irq_ack_o/irq_id_o one-cycle claim back to it; mie_i global enable;
// core_req_o/core_id_o/core_heti_o trap request to the core; core_gnt_i trap taken; core_mret_i handler return;
// level_o running context level (0 = thread mode); depth_o nesting depth.
// Optional macro IRQ_NEST_THRESH_EN adds thresh_i, a priority threshold a request must exceed.
module irq_nest_ctrl #(
  parameter int NrIrqLines   = 64,
  parameter int NrIrqPrios   = 32,
  parameter int MaxNestDepth = 4,
  parameter int IrqWidth     = $clog2(NrIrqLines),
  parameter int PrioWidth    = $clog2(NrIrqPrios),
  parameter int DepthWidth   = $clog2(MaxNestDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  irq_valid_i,
  input  logic [IrqWidth-1:0]   irq_id_i,
  input  logic [PrioWidth-1:0]  irq_level_i,
  input  logic                  irq_heti_i,
  input  logic                  irq_nest_i,
  output logic                  irq_ack_o,
  output logic [IrqWidth-1:0]   irq_id_o,
  input  logic                  mie_i,
`ifdef IRQ_NEST_THRESH_EN
  input  logic [PrioWidth-1:0]  thresh_i,
`endif
  output logic                  core_req_o,
  output logic [IrqWidth-1:0]   core_id_o,
  output logic                  core_heti_o,
  input  logic                  core_gnt_i,
  input  logic                  core_mret_i,
  output logic [PrioWidth-1:0]  level_o,
  output logic [DepthWidth-1:0] depth_o
);
  localparam int IdxWidth = (MaxNestDepth > 1) ? $clog2(MaxNestDepth) : 1;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_e;
  state_e                r_state, w_next;
  logic [IrqWidth-1:0]   r_id;
  logic [PrioWidth-1:0]  r_level;
  logic                  r_heti, r_nest;
  logic [PrioWidth-1:0]  r_lvl [MaxNestDepth];
  logic [MaxNestDepth-1:0] r_nst;
  logic [DepthWidth-1:0] r_depth;
  logic [IdxWidth-1:0]   w_top_idx, w_push_idx;
  logic [PrioWidth-1:0]  w_top_lvl, w_thresh;
  logic                  w_top_nst, w_empty, w_elig, w_retract, w_push, w_pop;
  assign w_empty    = r_depth == '0;
  assign w_top_idx  = IdxWidth'(r_depth - DepthWidth'(1));
  assign w_push_idx = IdxWidth'(r_depth);
  // an empty stack stands for thread mode: level 0, always preemptible
  assign w_top_lvl  = w_empty ? '0 : r_lvl[w_top_idx];
  assign w_top_nst  = w_empty | r_nst[w_top_idx];
`ifdef IRQ_NEST_THRESH_EN
  assign w_thresh   = thresh_i;
`else
  assign w_thresh   = '0;
`endif
  assign w_elig = irq_valid_i & mie_i & (irq_level_i != '0) & (irq_level_i > w_top_lvl) &
                  (irq_level_i > w_thresh) & w_top_nst & (r_depth < DepthWidth'(MaxNestDepth));
  // a pending request is only dropped for controller/enable changes, not for a level change from mret
  assign w_retract = ~irq_valid_i | (irq_id_i != r_id) | ~mie_i | (r_level <= w_thresh);
  assign w_push    = r_state == S_ACK;
  assign w_pop     = core_mret_i & ~w_empty;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == S_IDLE) ? (w_elig ? S_REQ : S_IDLE) :
             (r_state == S_REQ)  ? (core_gnt_i ? S_ACK : (w_retract ? S_IDLE : S_REQ)) :
             S_IDLE;
  end
  always_comb begin
    core_req_o  = r_state == S_REQ;
    core_id_o   = core_req_o ? r_id : '0;
    core_heti_o = core_req_o & r_heti;
    irq_ack_o   = r_state == S_ACK;
    irq_id_o    = irq_ack_o ? r_id : '0;
    level_o     = w_top_lvl;
    depth_o     = r_depth;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id    <= '0;
      r_level <= '0;
      r_heti  <= 1'b0;
      r_nest  <= 1'b0;
    end else if (r_state == S_IDLE && w_elig) begin
      r_id    <= irq_id_i;
      r_level <= irq_level_i;
      r_heti  <= irq_heti_i;
      r_nest  <= irq_nest_i;
    end
  end
  // simultaneous push and pop overwrites the top entry in place
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_depth <= '0;
      r_nst   <= '0;
      for (int k = 0; k < MaxNestDepth; k++) r_lvl[k] <= '0;
    end else if (w_push && w_pop) begin
      r_lvl[w_top_idx] <= r_level;
      r_nst[w_top_idx] <= r_nest;
    end else if (w_push) begin
      r_lvl[w_push_idx] <= r_level;
      r_nst[w_push_idx] <= r_nest;
      r_depth           <= r_depth + DepthWidth'(1);
    end else if (w_pop) begin
      r_depth <= r_depth - DepthWidth'(1);
    end
  end
endmodule

// File: doc/irq_nest_ctrl.md
Name: irq_nest_ctrl

Overview:
- Core-side endpoint of the controller-to-core interrupt interface. Consumes the arbitrated request (valid, id, level, heti, nest) from the interrupt controller and decides whether the request may preempt the current context.
- Raises a trap request to the core. On the core's grant it returns the claim acknowledge and id to the controller.
- Tracks nested handler levels in a small hardware stack that is popped on mret.

Parameters:
- NrIrqLines, 64, number of interrupt lines; IrqWidth = $clog2(NrIrqLines)
- NrIrqPrios, 32, number of priority levels; PrioWidth = $clog2(NrIrqPrios)
- MaxNestDepth, 4, maximum number of simultaneously active handlers; DepthWidth = $clog2(MaxNestDepth+1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- irq_valid_i  in  1  controller has an enabled, pending interrupt
- irq_id_i  in  IrqWidth  id of the winning line
- irq_level_i  in  PrioWidth  priority of the winning line
- irq_heti_i  in  1  winning line uses the HETI fast path
- irq_nest_i  in  1  winning line's handler may itself be preempted
- irq_ack_o  out  1  one-cycle claim pulse to the controller
- irq_id_o  out  IrqWidth  id being claimed; meaningful while irq_ack_o is high
- mie_i  in  1  global interrupt enable from the core CSR
- core_req_o  out  1  trap request to the core
- core_id_o  out  IrqWidth  latched id of the request
- core_heti_o  out  1  latched heti attribute of the request
- core_gnt_i  in  1  core takes the trap this cycle
- core_mret_i  in  1  core retires an mret this cycle
- level_o  out  PrioWidth  level of the running context; 0 = thread mode
- depth_o  out  DepthWidth  current nesting depth

Behaviour:
- Reset: all outputs 0, FSM in IDLE, stack cleared, depth 0, level_o 0.
- Running context = top-of-stack {level, nest}. When depth 0, the context is {0, nest=1}.
- eligible = irq_valid_i & mie_i & (irq_level_i != 0) & (irq_level_i > level_o) & top.nest & (depth < MaxNestDepth).
- FSM states: IDLE, REQ, ACK.
- IDLE:
  - If eligible, latch id, level, heti and nest, then go to REQ next cycle.
  - Outputs are registered, so core_req_o rises 1 cycle after eligible.
- REQ:
  - core_req_o = 1; core_id_o and core_heti_o are driven from the latches.
  - If core_gnt_i is high, go to ACK.
  - Otherwise, if irq_valid_i drops, or irq_id_i differs from the latched id, or mie_i drops, retract: core_req_o falls next cycle and the FSM returns to IDLE.
  - core_gnt_i has priority over retraction in the same cycle.
- ACK (exactly 1 cycle):
  - irq_ack_o = 1 and irq_id_o = latched id.
  - Push {level, nest}; depth increments.
  - Return to IDLE.
  - Minimum spacing between two claims is 3 cycles.
- mret:
  - core_mret_i with depth > 0 pops the stack next cycle.
  - core_mret_i with depth 0 is ignored; stack and level stay 0.
  - core_mret_i while in REQ pops the stack and re-evaluates nothing; the pending request continues and is not revalidated against the new level.
  - Push (ACK) and pop (mret) in the same cycle: top entry is replaced by the new entry and depth is unchanged.
- level_o and depth_o are registered and reflect the stack state after each update.
- Full stack (depth == MaxNestDepth): no new requests are raised until an mret occurs.
- Reset asserted mid-operation: immediate asynchronous return to the reset state. Any in-flight request or ack pulse is dropped.

Optional Feature:
- Macro: IRQ_NEST_THRESH_EN.
- Defined:
  - Adds input thresh_i [PrioWidth].
  - eligible additionally requires irq_level_i > thresh_i.
  - thresh_i is sampled every cycle; a raise while in REQ retracts the request as in the retraction rule.
- Undefined: no thresh_i port; effective threshold is 0.

Test Plan:
- Reset, then irq_valid_i=1, id=5, level=3, nest=1, mie_i=1 -> core_req_o=1 with core_id_o=5; on core_gnt_i, irq_ack_o pulses one cycle with irq_id_o=5; level_o=3, depth_o=1.
- While level 3 is active, present level 2 -> no core_req_o. Present level 7 -> request, ack, level_o=7, depth_o=2. Apply mret twice -> level_o 3, then 0.
- Active handler taken with nest=0, then present level 31 -> no request until mret.
- In REQ with id=9, change irq_id_i to 4 before core_gnt_i -> core_req_o deasserts, FSM returns to IDLE, and the new request for id 4 follows.
- Take 4 nested interrupts at levels 1, 2, 3, 4 -> depth_o=4; present level 5 -> no request. Apply mret at depth 0 after 4 pops -> depth_o stays 0.
- ACK cycle with simultaneous core_mret_i at depth 1 (level 2), new level 6 -> depth_o=1, level_o=6. With IRQ_NEST_THRESH_EN, thresh_i=10 and level 8 -> no request.
